icw_ocw_sequencer: RTL

- Consumes the one-cycle write strobe, A0 and internal data bus produced by Bus_Control_Logic.
- Runs the 8259A initialization sequence ICW1 → ICW2 → (ICW3) → (ICW4).
- Holds all programmed configuration, mask and read-select state.
- Emits one-cycle OCW2/OCW3 command pulses to the priority resolver and in-service logic downstream.

---
 rtl/pic_pkg.sv | 40 ++++
 rtl/icw_ocw_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pic_pkg.sv
// Shared encodings for the 8259A-style ICW/OCW command sequencer:
// FSM states, OCW2 command codes and command-byte bit positions.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } state_t;

  // OCW2 {R,SL,EOI} command codes
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] NS_EOI       = 3'b001;
  localparam logic [2:0] NOP          = 3'b010;
  localparam logic [2:0] SP_EOI       = 3'b011;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] SET_PRIO     = 3'b110;
  localparam logic [2:0] ROT_SP_EOI   = 3'b111;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SEL  = 4;

  localparam int ICW4_AEOI = 1;
  localparam int ICW4_BUF0 = 2;
  localparam int ICW4_BUF1 = 3;
  localparam int ICW4_SFNM = 4;

  localparam int OCW_SEL3  = 3;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

endpackage

// File: rtl/icw_ocw_sequencer.sv
// Decodes CPU writes into the ICW1..ICW4 init sequence and OCW1..OCW3 commands.
// All outputs registered one clk after write_pulse; pulses last one cycle; no backpressure.
module icw_ocw_sequencer
  import pic_pkg::*;
#(
  parameter logic [4:0] RESET_VECTOR_BASE = 5'b00000
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       write_pulse,
  input  logic       A0,
  input  logic [7:0] internal_bus,
  output logic       init_done,
  output logic       init_clear,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       aeoi,
  output logic [1:0] buf_ms,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       rotate_on_aeoi,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr_sel,
  output logic       special_mask,
  output logic       poll_pulse
);

  state_t r_state;
  logic   r_ic4;
  logic   w_icw1;

  assign w_icw1 = !A0 && internal_bus[ICW1_SEL];

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      r_state        <= ST_IDLE;
      r_ic4          <= 1'b0;
      init_done      <= 1'b0;
      init_clear     <= 1'b0;
      ltim           <= 1'b0;
      sngl           <= 1'b0;
      vector_base    <= RESET_VECTOR_BASE;
      cascade_cfg    <= 8'h00;
      aeoi           <= 1'b0;
      buf_ms         <= 2'b00;
      sfnm           <= 1'b0;
      imr            <= 8'hFF;
      rotate_on_aeoi <= 1'b0;
      ocw2_valid     <= 1'b0;
      ocw2_cmd       <= 3'b000;
      ocw2_level     <= 3'b000;
      read_isr_sel   <= 1'b0;
      special_mask   <= 1'b0;
      poll_pulse     <= 1'b0;
    end else begin
      init_clear <= 1'b0;
      ocw2_valid <= 1'b0;
      poll_pulse <= 1'b0;
      if (write_pulse) begin
        if (w_icw1) begin
          // ICW1 restarts the sequence from any state
          ltim           <= internal_bus[ICW1_LTIM];
          sngl           <= internal_bus[ICW1_SNGL];
          r_ic4          <= internal_bus[ICW1_IC4];
          imr            <= 8'h00;
          special_mask   <= 1'b0;
          read_isr_sel   <= 1'b0;
          rotate_on_aeoi <= 1'b0;
          if (!internal_bus[ICW1_IC4]) begin
            aeoi   <= 1'b0;
            sfnm   <= 1'b0;
            buf_ms <= 2'b00;
          end
          init_clear <= 1'b1;
          init_done  <= 1'b0;
          r_state    <= ST_WAIT_ICW2;
        end else begin
          case (r_state)
            ST_WAIT_ICW2: if (A0) begin
              vector_base <= internal_bus[7:3];
              if (!sngl) begin
                r_state <= ST_WAIT_ICW3;
              end else if (r_ic4) begin
                r_state <= ST_WAIT_ICW4;
              end else begin
                r_state   <= ST_READY;
                init_done <= 1'b1;
              end
            end
            ST_WAIT_ICW3: if (A0) begin
              cascade_cfg <= internal_bus;
              if (r_ic4) begin
                r_state <= ST_WAIT_ICW4;
              end else begin
                r_state   <= ST_READY;
                init_done <= 1'b1;
              end
            end
            ST_WAIT_ICW4: if (A0) begin
              sfnm      <= internal_bus[ICW4_SFNM];
              buf_ms    <= {internal_bus[ICW4_BUF1], internal_bus[ICW4_BUF0]};
              aeoi      <= internal_bus[ICW4_AEOI];
              r_state   <= ST_READY;
              init_done <= 1'b1;
            end
            ST_READY: begin
              if (A0) begin
                imr <= internal_bus;
              end else if (!internal_bus[OCW_SEL3]) begin
                ocw2_cmd   <= internal_bus[7:5];
                ocw2_level <= internal_bus[2:0];
                ocw2_valid <= 1'b1;
                if (internal_bus[7:5] == ROT_AEOI_SET) begin
                  rotate_on_aeoi <= 1'b1;
                end else if (internal_bus[7:5] == ROT_AEOI_CLR) begin
                  rotate_on_aeoi <= 1'b0;
                end
              end else begin
                if (internal_bus[OCW3_RR]) begin
                  read_isr_sel <= internal_bus[OCW3_RIS];
                end
                if (internal_bus[OCW3_ESMM]) begin
                  special_mask <= internal_bus[OCW3_SMM];
                end
                poll_pulse <= internal_bus[OCW3_P];
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule
